// File: rtl/de_frame.sv
// de_frame: UART Rx deframer; registers start/data/parity/stop on recieved_flag.
// Define DE_FRAME_ERR_CHECK_EN to add registered frame_error and parity_error.
module de_frame #(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        recieved_flag,
  input  logic [10:0] data_parll,
  output logic        start_bit,
  output logic [7:0]  raw_data,
  output logic        parity_bit,
  output logic        stop_bit,
  output logic        data_valid
`ifdef DE_FRAME_ERR_CHECK_EN
  ,
  output logic        frame_error,
  output logic        parity_error
`endif
);

  // Idle-mark line level: every field reads as 1 after reset.
  localparam logic [10:0] IDLE = 11'h7FF;

  function automatic logic par_err(input logic [10:0] f);
    return ((^f[8:1]) ^ PARITY_ODD) != f[9];
  endfunction

  logic [10:0] frame_q, frame_d;
  logic        valid_q, valid_d;

  always_comb begin
    frame_d = frame_q;
    valid_d = recieved_flag;
    if (recieved_flag)
      frame_d = data_parll;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      frame_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      frame_q <= frame_d;
      valid_q <= valid_d;
    end
  end

  assign start_bit  = frame_q[0];
  assign raw_data   = frame_q[8:1];
  assign parity_bit = frame_q[9];
  assign stop_bit   = frame_q[10];
  assign data_valid = valid_q;

`ifdef DE_FRAME_ERR_CHECK_EN
  logic ferr_q, ferr_d;
  logic perr_q, perr_d;

  always_comb begin
    ferr_d = ferr_q;
    perr_d = perr_q;
    if (recieved_flag) begin
      ferr_d = data_parll[0] | ~data_parll[10];
      perr_d = par_err(data_parll);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
      perr_q <= perr_d;
    end
  end

  assign frame_error  = ferr_q;
  assign parity_error = perr_q;
`endif

endmodule

// File: tb/tb_de_frame.sv
// tb_de_frame: scoreboard bench for de_frame, even and odd parity instances.
// Checks error flags only when DE_FRAME_ERR_CHECK_EN is defined.
module tb_de_frame;

  typedef struct packed {
    logic       s;
    logic [7:0] d;
    logic       p;
    logic       st;
    logic       v;
    logic       fe;
    logic       pe;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flag = 1'b1;
  logic [10:0] din = 11'h000;

  logic       s0, p0, st0, v0, fe0, pe0;
  logic [7:0] d0;
  logic       s1, p1, st1, v1, fe1, pe1;
  logic [7:0] d1;

  always #5 clock = ~clock;

  de_frame #(.PARITY_ODD(1'b0)) u_even (
    .clock(clock), .reset_n(reset_n),
    .recieved_flag(flag), .data_parll(din),
    .start_bit(s0), .raw_data(d0),
    .parity_bit(p0), .stop_bit(st0),
    .data_valid(v0)
`ifdef DE_FRAME_ERR_CHECK_EN
    , .frame_error(fe0), .parity_error(pe0)
`endif
  );

  de_frame #(.PARITY_ODD(1'b1)) u_odd (
    .clock(clock), .reset_n(reset_n),
    .recieved_flag(flag), .data_parll(din),
    .start_bit(s1), .raw_data(d1),
    .parity_bit(p1), .stop_bit(st1),
    .data_valid(v1)
`ifdef DE_FRAME_ERR_CHECK_EN
    , .frame_error(fe1), .parity_error(pe1)
`endif
  );

`ifndef DE_FRAME_ERR_CHECK_EN
  assign fe0 = 1'b0;
  assign pe0 = 1'b0;
  assign fe1 = 1'b0;
  assign pe1 = 1'b0;
`endif

  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference: a UART frame with idle-mark reset, capture, or hold.
  function automatic exp_t model(input exp_t cur, input bit r,
                                 input bit f, input logic [10:0] fr,
                                 input bit podd);
    exp_t n;
    int   ones;
    n = cur;
    if (!r) begin
      n = '{s: 1, d: 8'hFF, p: 1, st: 1, v: 0, fe: 0, pe: 0};
    end else if (f) begin
      n.s  = fr[0];
      n.d  = fr[8:1];
      n.p  = fr[9];
      n.st = fr[10];
      n.v  = 1'b1;
      n.fe = !(fr[0] == 1'b0 && fr[10] == 1'b1);
      ones = $countones(fr[9:1]);
      n.pe = ((ones % 2) == 1) != podd;
    end else begin
      n.v = 1'b0;
    end
`ifndef DE_FRAME_ERR_CHECK_EN
    n.fe = 1'b0;
    n.pe = 1'b0;
`endif
    return n;
  endfunction

  task automatic step(input bit r, input bit f, input logic [10:0] fr);
    reset_n = r;
    flag    = f;
    din     = fr;
    @(posedge clock);
    m0 = model(m0, r, f, fr, 1'b0);
    m1 = model(m1, r, f, fr, 1'b1);
    q0.push_back(m0);
    q1.push_back(m1);
    #1;
  endtask

  task automatic chk(input string nm, input exp_t a, input exp_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got s=%b d=%h p=%b st=%b v=%b fe=%b pe=%b, want s=%b d=%h p=%b st=%b v=%b fe=%b pe=%b",
               nm, a.s, a.d, a.p, a.st, a.v, a.fe, a.pe,
               e.s, e.d, e.p, e.st, e.v, e.fe, e.pe);
    end
  endtask

  always @(negedge clock) begin
    exp_t a, e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = '{s: s0, d: d0, p: p0, st: st0, v: v0, fe: fe0, pe: pe0};
      chk("even", a, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = '{s: s1, d: d1, p: p1, st: st1, v: v1, fe: fe1, pe: pe1};
      chk("odd", a, e);
    end
  end

  initial begin
    m0 = '0;
    m1 = '0;
    step(0, 1, 11'h000);
    step(0, 1, 11'h000);
    step(1, 1, 11'h54A);
    step(1, 1, 11'h602);
    step(1, 1, 11'h74A);
    step(1, 1, 11'h14A);
    step(1, 1, 11'h54B);
    step(1, 1, 11'h54A);
    repeat (3) step(1, 0, 11'h7FF);
    for (int i = 0; i < 20; i++)
      step(1, 1, 11'($urandom));
    step(0, 1, 11'($urandom));
    step(1, 1, 11'($urandom));
    step(1, 1, 11'($urandom));
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 19) != 0),
           $urandom_range(0, 1) == 1,
           11'($urandom));
    repeat (2) @(posedge clock);
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d left, want 0/0",
               q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/de_frame.md
# de_frame

Receive-side UART deframer. Takes the 11-bit frame produced by the receiver's serial-to-parallel stage and registers its fields on a single clock when the receive-done flag is asserted: start bit, 8 data bits, parity bit and stop bit. It sits between the Rx SIPO shift register and the parity/error checker and the Rx output register, so downstream logic sees stable, separated fields.

## Interface
Parameters:
- PARITY_ODD, default 0: parity sense used by the optional checker. 0 = even (data + parity bit has an even number of ones); 1 = odd.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
- recieved_flag  input  1  frame-complete strobe/level from the SIPO; data_parll is valid while it is high.
- data_parll  input  11  received frame, LSB first on the line: [0] start, [8:1] data (bit 1 = data LSB), [9] parity, [10] stop.
- start_bit  output  1  registered data_parll[0].
- raw_data  output  8  registered data_parll[8:1].
- parity_bit  output  1  registered data_parll[9].
- stop_bit  output  1  registered data_parll[10].
- data_valid  output  1  one-cycle pulse marking a new capture.
- frame_error  output  1  (DE_FRAME_ERR_CHECK_EN only) registered start≠0 or stop≠1.
- parity_error  output  1  (DE_FRAME_ERR_CHECK_EN only) registered parity mismatch.

## Operation
- Single-state datapath with capture enable; no FSM.
- Reset (reset_n=0 at a clock edge) has priority over everything: start_bit=1, raw_data=8'hFF, parity_bit=1, stop_bit=1 (idle-mark pattern), data_valid=0, frame_error=0, parity_error=0.
- Capture: reset_n=1 and recieved_flag=1 at an edge → all four field outputs load from data_parll exactly as mapped above. data_valid=1 for that cycle.
- Hold: reset_n=1 and recieved_flag=0 → field outputs and error flags keep their last values. data_valid=0.
- recieved_flag held high for N cycles → a capture on every edge. data_valid stays high, and the outputs track data_parll with a 1-cycle lag. No edge detection.
- Parity check: computed = ^data_parll[8:1] XOR PARITY_ODD. parity_error = (computed ≠ data_parll[9]).
- Frame check: frame_error = (data_parll[0] ≠ 0) | (data_parll[10] ≠ 1).
- Error flags are computed from the same data_parll sample that loads the fields. They are updated only on capture.
- No X-propagation guarantees on unused inputs. data_parll is don't-care when recieved_flag=0.

## Timing
- Latency: 1 clock from the capture edge to valid outputs. Outputs are purely registered, with no combinational path from input to output.
- Reset is synchronous. Asserting reset_n mid-stream clears the outputs at the next edge even if recieved_flag=1, and that frame is discarded.
- Reset released with recieved_flag=1 already high → capture occurs on the first edge with reset_n=1.
- data_parll may change every cycle. Only the value present at the capturing edge matters.

## Configuration
- DE_FRAME_ERR_CHECK_EN defined: parity_error and frame_error ports and their logic exist as specified.
- Not defined: both ports are absent. The parity and frame logic is not synthesized. Field outputs and data_valid behave identically.

## Test plan
- Reset: reset_n=0 for 1 edge with recieved_flag=1 and data_parll=11'h000 → start/parity/stop=1, raw_data=8'hFF, data_valid=0, errors=0.
- Good frame, even parity: PARITY_ODD=0, recieved_flag=1, data_parll=11'h54A → next cycle raw_data=8'hA5, start=0, parity=0, stop=1, data_valid=1, both errors=0.
- Parity bit set: data_parll=11'h602 → raw_data=8'h01, parity_bit=1, parity_error=0. Then data_parll=11'h74A → raw_data=8'hA5, parity_error=1. With PARITY_ODD=1, 11'h74A gives parity_error=0.
- Framing errors: 11'h14A (stop=0) → frame_error=1, stop_bit=0. 11'h54B (start=1) → frame_error=1, start_bit=1. raw_data=8'hA5 in both cases.
- Hold: capture 11'h54A, drop recieved_flag, then drive 11'h7FF for 3 cycles → outputs unchanged, data_valid=0.
- Reset mid-stream: recieved_flag=1 streaming random frames, then reset_n=0 for one edge → idle-mark outputs on that edge. Capture resumes on the next edge with reset_n=1.
